// File: rtl/wall_state_ctrl.sv
// ---------------------------------------------------------------------------
// wall_state_ctrl
//
// Game-logic stage feeding the wall sprite renderers. Tracks the hit points
// and life state (ALIVE / FLASH / DYING / DEAD) of each defensive wall. It
// applies projectile hits from the collision logic and steps the per-wall
// flash timers on the frame tick. A wall flashes (freeze high) after every
// hit. Once its HP is exhausted and the final flash ends, it disappears
// (enable low).
//
// Optional feature macro: WALL_REGEN_EN
//   When defined, an ALIVE wall with 0 < HP < WALL_HP regains one HP every
//   REGEN_FRAMES frame ticks. When undefined, HP only ever decreases.
//
// Ports:
//   clk            in   1            system clock
//   rst_n          in   1            synchronous active-low reset
//   frame_tick     in   1            one-cycle pulse per frame
//   restart        in   1            one-cycle pulse; restores all walls
//   hit_valid      in   1            one-cycle pulse; a projectile hit a wall
//   hit_idx        in   3            index of the wall that was hit
//   hit_accepted   out  1            pulse; the hit changed wall state
//   wall_enable    out  NUM_WALLS    per-wall renderer enable
//   wall_freeze    out  NUM_WALLS    per-wall renderer freeze/flash
//   wall_hp        out  NUM_WALLS*4  packed HP; wall i at [4i+3:4i]
//   all_destroyed  out  1            high while every wall is DEAD
//
// All outputs are registered and reflect an input event one cycle later.
// ---------------------------------------------------------------------------
module wall_state_ctrl #(
    parameter int NUM_WALLS    = 4,
    parameter int WALL_HP      = 4,
    parameter int FLASH_FRAMES = 8,
    parameter int REGEN_FRAMES = 120
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_tick,
    input  logic                   restart,
    input  logic                   hit_valid,
    input  logic [2:0]             hit_idx,
    output logic                   hit_accepted,
    output logic [NUM_WALLS-1:0]   wall_enable,
    output logic [NUM_WALLS-1:0]   wall_freeze,
    output logic [NUM_WALLS*4-1:0] wall_hp,
    output logic                   all_destroyed
);

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_FLASH = 2'd1,
        ST_DYING = 2'd2,
        ST_DEAD  = 2'd3
    } wall_state_t;

    localparam logic [3:0] HP_INIT    = 4'(WALL_HP);
    localparam logic [5:0] FLASH_INIT = 6'(FLASH_FRAMES);

    // Elaboration-time legality check of the configuration.
    if (NUM_WALLS < 1 || NUM_WALLS > 8 || WALL_HP < 1 || WALL_HP > 15 ||
        FLASH_FRAMES < 1 || FLASH_FRAMES > 63 ||
        REGEN_FRAMES < 1 || REGEN_FRAMES > 255) begin : g_bad_params
        $error("wall_state_ctrl: parameter out of range");
    end

    // Per-wall state
    wall_state_t r_state     [NUM_WALLS];
    wall_state_t w_state_nxt [NUM_WALLS];
    logic [3:0]  r_hp        [NUM_WALLS];
    logic [3:0]  w_hp_nxt    [NUM_WALLS];
    logic [5:0]  r_flash     [NUM_WALLS];
    logic [5:0]  w_flash_nxt [NUM_WALLS];
`ifdef WALL_REGEN_EN
    localparam logic [7:0] REGEN_LAST = 8'(REGEN_FRAMES - 1);
    logic [7:0]  r_regen     [NUM_WALLS];
    logic [7:0]  w_regen_nxt [NUM_WALLS];
`endif

    // Registered outputs and their next values
    logic                   r_hit_accepted;
    logic [NUM_WALLS-1:0]   r_wall_enable;
    logic [NUM_WALLS-1:0]   r_wall_freeze;
    logic [NUM_WALLS*4-1:0] r_wall_hp;
    logic                   r_all_destroyed;

    logic                   w_hit_accepted;
    logic [NUM_WALLS-1:0]   w_wall_enable;
    logic [NUM_WALLS-1:0]   w_wall_freeze;
    logic [NUM_WALLS*4-1:0] w_wall_hp;
    logic [NUM_WALLS-1:0]   w_hit_sel;

    // One-hot hit decode. An index >= NUM_WALLS matches no wall, so
    // out-of-range hits fall out naturally and are ignored.
    always_comb begin
        w_hit_sel = '0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            w_hit_sel[i] = hit_valid && (int'(hit_idx) == i);
        end
    end

    // Next-state and next-output logic.
    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        w_hit_accepted = 1'b0;
        w_wall_enable  = '0;
        w_wall_freeze  = '0;
        w_wall_hp      = '0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_hp_nxt[i]    = r_hp[i];
            w_flash_nxt[i] = r_flash[i];
`ifdef WALL_REGEN_EN
            w_regen_nxt[i] = r_regen[i];
`endif
            if (restart) begin
                w_state_nxt[i] = ST_ALIVE;
                w_hp_nxt[i]    = HP_INIT;
                w_flash_nxt[i] = '0;
`ifdef WALL_REGEN_EN
                w_regen_nxt[i] = '0;
`endif
            end else begin
                case (r_state[i])
                    ST_ALIVE, ST_FLASH: begin
                        // A hit takes priority over the tick on this wall:
                        // the flash timer reloads instead of counting down.
                        if (w_hit_sel[i] && r_hp[i] != 4'd0) begin
                            w_hit_accepted = 1'b1;
                            w_hp_nxt[i]    = r_hp[i] - 4'd1;
                            w_flash_nxt[i] = FLASH_INIT;
                            w_state_nxt[i] = (r_hp[i] == 4'd1) ? ST_DYING : ST_FLASH;
`ifdef WALL_REGEN_EN
                            w_regen_nxt[i] = '0;
`endif
                        end else if (frame_tick) begin
                            if (r_state[i] == ST_FLASH) begin
                                if (r_flash[i] != 6'd0) begin
                                    w_flash_nxt[i] = r_flash[i] - 6'd1;
                                    if (r_flash[i] == 6'd1) begin
                                        w_state_nxt[i] = ST_ALIVE;
                                    end
                                end
                            end
`ifdef WALL_REGEN_EN
                            else if (r_hp[i] != 4'd0 && r_hp[i] < HP_INIT) begin
                                if (r_regen[i] == REGEN_LAST) begin
                                    w_hp_nxt[i]    = r_hp[i] + 4'd1;
                                    w_regen_nxt[i] = '0;
                                end else begin
                                    w_regen_nxt[i] = r_regen[i] + 8'd1;
                                end
                            end
`endif
                        end
                    end
                    ST_DYING: begin
                        if (frame_tick && r_flash[i] != 6'd0) begin
                            w_flash_nxt[i] = r_flash[i] - 6'd1;
                            if (r_flash[i] == 6'd1) begin
                                w_state_nxt[i] = ST_DEAD;
                            end
                        end
                    end
                    default: begin
                        // DEAD: hold with HP=0 until restart or reset.
                    end
                endcase
            end
            w_wall_enable[i]     = (w_state_nxt[i] != ST_DEAD);
            w_wall_freeze[i]     = (w_state_nxt[i] == ST_FLASH) ||
                                   (w_state_nxt[i] == ST_DYING);
            w_wall_hp[i*4 +: 4]  = w_hp_nxt[i];
        end
    end

    // State and output registers.
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples its inputs from before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // The per-wall arrays are a handful of flops rather than a RAM,
            // so they are all cleared explicitly.
            for (int i = 0; i < NUM_WALLS; i++) begin
                r_state[i] <= ST_ALIVE;
                r_hp[i]    <= HP_INIT;
                r_flash[i] <= '0;
`ifdef WALL_REGEN_EN
                r_regen[i] <= '0;
`endif
            end
            r_hit_accepted  <= 1'b0;
            r_wall_enable   <= '1;
            r_wall_freeze   <= '0;
            r_wall_hp       <= {NUM_WALLS{HP_INIT}};
            r_all_destroyed <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WALLS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_hp[i]    <= w_hp_nxt[i];
                r_flash[i] <= w_flash_nxt[i];
`ifdef WALL_REGEN_EN
                r_regen[i] <= w_regen_nxt[i];
`endif
            end
            r_hit_accepted  <= w_hit_accepted;
            r_wall_enable   <= w_wall_enable;
            r_wall_freeze   <= w_wall_freeze;
            r_wall_hp       <= w_wall_hp;
            r_all_destroyed <= (w_wall_enable == '0);
        end
    end

    assign hit_accepted  = r_hit_accepted;
    assign wall_enable   = r_wall_enable;
    assign wall_freeze   = r_wall_freeze;
    assign wall_hp       = r_wall_hp;
    assign all_destroyed = r_all_destroyed;

endmodule

// File: tb/tb_wall_state_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for wall_state_ctrl.
// A reference model tracks each wall as {hp, flash timer, dead flag, regen
// count}; the life state is implied by those values. Every cycle's outputs are
// compared with the model. A table of hand-derived vectors and several
// multi-cycle sequences add fixed expected values.
// ---------------------------------------------------------------------------
module tb_wall_state_ctrl;

    localparam int NW    = 4;
    localparam int HP0   = 4;
    localparam int FF    = 8;
    localparam int REGEN = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_tick = 1'b0;
    logic            restart = 1'b0;
    logic            hit_valid = 1'b0;
    logic [2:0]      hit_idx = 3'd0;
    logic            hit_accepted;
    logic [NW-1:0]   wall_enable;
    logic [NW-1:0]   wall_freeze;
    logic [NW*4-1:0] wall_hp;
    logic            all_destroyed;

    wall_state_ctrl #(
        .NUM_WALLS   (NW),
        .WALL_HP     (HP0),
        .FLASH_FRAMES(FF),
        .REGEN_FRAMES(REGEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .restart      (restart),
        .hit_valid    (hit_valid),
        .hit_idx      (hit_idx),
        .hit_accepted (hit_accepted),
        .wall_enable  (wall_enable),
        .wall_freeze  (wall_freeze),
        .wall_hp      (wall_hp),
        .all_destroyed(all_destroyed)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_hp    [NW];
    int m_timer [NW];
    int m_regen [NW];
    bit m_dead  [NW];
    bit m_acc;

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_hp[w] = HP0; m_timer[w] = 0; m_regen[w] = 0; m_dead[w] = 0;
        end
        m_acc = 0;
    endtask

    task automatic model_update(input bit rst_v, input bit rs_v, input bit tk_v,
                                input bit hv_v, input int idx);
        int hit_w;
        bit was_alive;
        if (!rst_v || rs_v) begin
            model_reset();
            return;
        end
        hit_w = -1;
        m_acc = 0;
        // A wall can take a hit while it is not dead and has HP left.
        if (hv_v && idx < NW) begin
            if (!m_dead[idx] && m_hp[idx] > 0) begin
                hit_w = idx;
                m_acc = 1;
            end
        end
        for (int w = 0; w < NW; w++) begin
            if (w == hit_w) begin
                m_hp[w]--;
                m_timer[w] = FF;
                m_regen[w] = 0;
            end else if (tk_v) begin
                was_alive = !m_dead[w] && m_timer[w] == 0;
                if (m_timer[w] > 0) begin
                    m_timer[w]--;
                    if (m_timer[w] == 0 && m_hp[w] == 0) m_dead[w] = 1;
                end
`ifdef WALL_REGEN_EN
                if (was_alive && m_hp[w] > 0 && m_hp[w] < HP0) begin
                    m_regen[w]++;
                    if (m_regen[w] == REGEN) begin
                        m_hp[w]++;
                        m_regen[w] = 0;
                    end
                end
`else
                if (was_alive) m_regen[w] = 0;
`endif
            end
        end
    endtask

    task automatic compare_model();
        logic [NW-1:0]   e_en, e_fr;
        logic [NW*4-1:0] e_hp;
        logic            e_all;
        e_all = 1'b1;
        for (int w = 0; w < NW; w++) begin
            e_en[w] = !m_dead[w];
            e_fr[w] = (m_timer[w] > 0);
            e_hp[w*4 +: 4] = 4'(m_hp[w]);
            if (!m_dead[w]) e_all = 1'b0;
        end
        check("model_hit_accepted", 32'(hit_accepted), 32'(m_acc));
        check("model_wall_enable", 32'(wall_enable), 32'(e_en));
        check("model_wall_freeze", 32'(wall_freeze), 32'(e_fr));
        check("model_wall_hp", 32'(wall_hp), 32'(e_hp));
        check("model_all_destroyed", 32'(all_destroyed), 32'(e_all));
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 time unit
    // after the edge and compare against the model.
    task automatic step(input bit rst_v, input bit rs_v, input bit tk_v,
                        input bit hv_v, input int idx);
        rst_n      = rst_v;
        restart    = rs_v;
        frame_tick = tk_v;
        hit_valid  = hv_v;
        hit_idx    = 3'(idx);
        @(posedge clk);
        model_update(rst_v, rs_v, tk_v, hv_v, idx);
        #1;
        compare_model();
    endtask

    task automatic idle();      step(1, 0, 0, 0, 0);   endtask
    task automatic tick();      step(1, 0, 1, 0, 0);   endtask
    task automatic hit(input int idx); step(1, 0, 0, 1, idx); endtask
    task automatic do_restart(); step(1, 1, 0, 0, 0);  endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst_v;
        bit         rs_v;
        bit         tk_v;
        bit         hv_v;
        int         idx;
        bit         exp_acc;
        logic [3:0] exp_en;
        logic [3:0] exp_fr;
        logic [15:0] exp_hp;
        bit         exp_all;
    } vec_t;

    vec_t vecs [8];

    initial begin
        model_reset();
        vecs[0] = '{0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 16'h4444, 0}; // reset
        vecs[1] = '{1, 0, 0, 0, 0, 0, 4'hF, 4'h0, 16'h4444, 0}; // idle
        vecs[2] = '{1, 0, 0, 1, 2, 1, 4'hF, 4'h4, 16'h4344, 0}; // hit wall 2
        vecs[3] = '{1, 0, 0, 1, 5, 0, 4'hF, 4'h4, 16'h4344, 0}; // out of range
        vecs[4] = '{1, 0, 1, 1, 2, 1, 4'hF, 4'h4, 16'h4244, 0}; // hit+tick wall 2
        vecs[5] = '{1, 0, 0, 1, 0, 1, 4'hF, 4'h5, 16'h4243, 0}; // hit wall 0
        vecs[6] = '{1, 1, 0, 1, 1, 0, 4'hF, 4'h0, 16'h4444, 0}; // restart wins
        vecs[7] = '{1, 0, 1, 0, 0, 0, 4'hF, 4'h0, 16'h4444, 0}; // idle tick

        for (int v = 0; v < 8; v++) begin
            step(vecs[v].rst_v, vecs[v].rs_v, vecs[v].tk_v, vecs[v].hv_v, vecs[v].idx);
            check($sformatf("vec%0d_acc", v), 32'(hit_accepted), 32'(vecs[v].exp_acc));
            check($sformatf("vec%0d_en", v), 32'(wall_enable), 32'(vecs[v].exp_en));
            check($sformatf("vec%0d_fr", v), 32'(wall_freeze), 32'(vecs[v].exp_fr));
            check($sformatf("vec%0d_hp", v), 32'(wall_hp), 32'(vecs[v].exp_hp));
            check($sformatf("vec%0d_all", v), 32'(all_destroyed), 32'(vecs[v].exp_all));
        end

        // ---- single hit and flash expiry ----
        do_restart();
        hit(2);
        check("single_hit_acc", 32'(hit_accepted), 32'd1);
        check("single_hit_hp", 32'(wall_hp[11:8]), 32'd3);
        for (int t = 0; t < FF - 1; t++) tick();
        check("flash_before_expiry", 32'(wall_freeze), 32'h4);
        tick();
        check("flash_expired", 32'(wall_freeze), 32'h0);
        check("flash_expired_en", 32'(wall_enable), 32'hF);

        // ---- kill wall 0 with back-to-back hits ----
        do_restart();
        for (int h = 0; h < HP0; h++) hit(0);
        check("kill_hp0", 32'(wall_hp[3:0]), 32'd0);
        check("kill_freeze", 32'(wall_freeze[0]), 32'd1);
        for (int t = 0; t < FF - 1; t++) tick();
        check("dying_still_en", 32'(wall_enable[0]), 32'd1);
        tick();
        check("dead_en", 32'(wall_enable[0]), 32'd0);
        check("dead_freeze", 32'(wall_freeze[0]), 32'd0);
        hit(0);
        check("dead_hit_ignored", 32'(hit_accepted), 32'd0);
        check("dead_hp_zero", 32'(wall_hp[3:0]), 32'd0);

        // ---- same-cycle hit and tick reloads the flash timer ----
        do_restart();
        hit(1);
        for (int t = 0; t < FF - 3; t++) tick();   // 3 frames left
        step(1, 0, 1, 1, 1);                       // hit + tick on wall 1
        check("reload_acc", 32'(hit_accepted), 32'd1);
        check("reload_hp", 32'(wall_hp[7:4]), 32'd2);
        for (int t = 0; t < FF - 1; t++) tick();
        check("reload_still_flash", 32'(wall_freeze[1]), 32'd1);
        tick();
        check("reload_expired", 32'(wall_freeze[1]), 32'd0);
        hit(5);
        check("idx5_ignored", 32'(hit_accepted), 32'd0);
        check("idx5_hp", 32'(wall_hp), 32'h4424);

        // ---- wipe-out and restart ----
        do_restart();
        for (int w = 0; w < NW; w++)
            for (int h = 0; h < HP0; h++) hit(w);
        check("wipe_not_yet", 32'(all_destroyed), 32'd0);
        for (int t = 0; t < FF - 1; t++) tick();
        check("wipe_last_flash", 32'(all_destroyed), 32'd0);
        tick();
        check("wipe_all_destroyed", 32'(all_destroyed), 32'd1);
        check("wipe_enable", 32'(wall_enable), 32'h0);
        do_restart();
        check("restart_hp", 32'(wall_hp), 32'h4444);
        check("restart_en", 32'(wall_enable), 32'hF);
        check("restart_all", 32'(all_destroyed), 32'd0);
        hit(1);
        hit(1);
        for (int t = 0; t < 3; t++) tick();
        step(0, 1, 1, 1, 1);                       // reset mid-flash
        check("rst_hp", 32'(wall_hp), 32'h4444);
        check("rst_freeze", 32'(wall_freeze), 32'h0);
        check("rst_acc", 32'(hit_accepted), 32'd0);

        // ---- regeneration ----
        do_restart();
        hit(3);
        for (int t = 0; t < FF; t++) tick();
        for (int t = 0; t < REGEN; t++) tick();
`ifdef WALL_REGEN_EN
        check("regen_hp3", 32'(wall_hp[15:12]), 32'd4);
`else
        check("regen_hp3", 32'(wall_hp[15:12]), 32'd3);
`endif

        // ---- randomized stimulus against the model ----
        do_restart();
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 499) != 0),
                 ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 1),
                 int'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wall_state_ctrl.md
Name: wall_state_ctrl

Overview:
Game-logic stage directly upstream of the wall sprite renderers. Tracks hit points and life state for each defensive wall and drives each renderer's enable and freeze inputs. Accepts projectile-hit events from the collision logic and steps its flash timers on the per-frame tick. Walls flash (freeze high) after every hit, then disappear (enable low) once their HP is exhausted.

Parameters:
NUM_WALLS, 4, number of walls managed; 1..8
WALL_HP, 4, starting hit points per wall; 1..15
FLASH_FRAMES, 8, frames freeze stays high after a hit or a kill; 1..63
REGEN_FRAMES, 120, frames per +1 HP regeneration step; 1..255; used only with WALL_REGEN_EN

Ports:
clk  in  1  pixel/system clock
rst_n  in  1  synchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame (vsync start)
restart  in  1  one-cycle pulse; restores all walls
hit_valid  in  1  one-cycle pulse; a projectile hit a wall
hit_idx  in  3  index of the wall hit
hit_accepted  out  1  one-cycle pulse; the hit changed wall state
wall_enable  out  NUM_WALLS  per-wall renderer enable
wall_freeze  out  NUM_WALLS  per-wall renderer freeze/flash
wall_hp  out  NUM_WALLS*4  packed HP; wall i at bits [4i+3:4i]
all_destroyed  out  1  high while every wall is DEAD

Behaviour:
- Each wall has a 2-bit state: ALIVE, FLASH, DYING, DEAD.
- Each wall also has a 4-bit HP counter and a 6-bit flash counter.
- All outputs are registered. Any input event is visible on the outputs 1 cycle later.
- Reset (rst_n=0 at posedge clk) and restart=1 have identical effect:
  - every wall goes to ALIVE with HP=WALL_HP and flash counter 0
  - wall_enable all 1, wall_freeze all 0, hit_accepted 0, all_destroyed 0
  - rst_n has priority over restart; restart has priority over hit and tick on the same cycle.
- Hit handling applies when hit_valid=1 and hit_idx<NUM_WALLS:
  - ALIVE or FLASH: HP decrements by 1.
    - New HP>0: state becomes FLASH and the flash counter loads FLASH_FRAMES (a hit during FLASH reloads it).
    - New HP=0: state becomes DYING and the flash counter loads FLASH_FRAMES.
    - hit_accepted pulses in either case.
  - DYING, DEAD, or hit_idx>=NUM_WALLS: the hit is ignored and hit_accepted stays 0.
- Frame tick handling for each FLASH/DYING wall whose flash counter is >0 and that has no accepted hit this cycle:
  - the counter decrements by 1
  - when it reaches 0, FLASH goes to ALIVE and DYING goes to DEAD.
- Same-cycle hit and tick on the same wall: the hit wins (reload). Other walls still consume the tick.
- Output mapping:
  - wall_enable[i] = state != DEAD
  - wall_freeze[i] = state is FLASH or DYING
  - all_destroyed = all states DEAD
- HP never underflows. DEAD walls hold HP=0.
- Only one hit per cycle is possible by construction. Back-to-back hits on consecutive cycles must each be processed.

Optional Feature:
WALL_REGEN_EN
- Defined: each ALIVE wall with 0<HP<WALL_HP keeps an 8-bit regen counter.
  - The counter increments on frame_tick.
  - When it reaches REGEN_FRAMES, HP increments by 1 and the counter clears.
  - The counter clears on any accepted hit to that wall, on restart, and on reset.
  - FLASH, DYING and DEAD walls do not regenerate. DEAD walls never revive.
- Undefined: no regen counters exist and HP only decreases.

Test Plan:
1. Reset release, defaults: no hits -> wall_enable=4'b1111, wall_freeze=0, wall_hp=16'h4444, all_destroyed=0.
2. Single hit and flash expiry: hit_idx=2 -> next cycle hit_accepted=1, wall_hp[11:8]=3, wall_freeze=4'b0100; after 8 frame_ticks wall_freeze=0 and enable stays 1.
3. Kill: four hits on wall 0 -> HP=0, freeze=1 for 8 ticks, then wall_enable[0]=0; a fifth hit gives hit_accepted=0 and HP stays 0.
4. Collision of events: hit on wall 1 in the same cycle as frame_tick while wall 1 has 3 flash frames left -> counter reloads to 8. Hit with hit_idx=5 -> ignored, no state change.
5. Wipe-out and restart: kill all 4 walls -> all_destroyed=1 after the last flash expires. restart -> next cycle wall_hp=16'h4444, enable all 1, all_destroyed=0. Repeat with rst_n asserted mid-flash -> same defaults.
6. Regen, with WALL_REGEN_EN and REGEN_FRAMES=4: one hit on wall 3, let the flash expire, then 4 more ticks -> HP back to 4. Without the macro, HP stays 3.
